// File: rtl/int_to_fp.sv
// -----------------------------------------------------------------------------
// int_to_fp
//
// Sequential signed-integer to floating-point converter. It produces operands in
// the fp_adder format: sign, 4-bit exponent and 8-bit fraction with an explicit
// leading one, where value = (-1)^sign * 0.frac * 2^exp.
//
// A conversion latches the sign and magnitude, then normalises the magnitude
// with a 1-bit-per-cycle left shifter. Finally it rounds to nearest, ties to
// even. The latency is k+2 cycles from the start-sampling edge to done, where k
// is the number of leading zeros of the magnitude (k=0 for a zero input).
//
// Parameters
//   INT_W      two's-complement input width, legal range 9..15
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high reset
//   start      in   request a conversion; sampled only while ready=1
//   int_in     in   signed integer operand, sampled together with start
//   ready      out  high only while idle
//   done       out  one-cycle pulse, result outputs valid
//   sign_out   out  result sign
//   exp_out    out  result exponent (4 bits)
//   frac_out   out  result fraction (8 bits); bit 7 is 1 unless the result is zero
//   inexact    out  only when INT2FP_INEXACT_EN is defined; set when rounding
//                   discarded non-zero bits
//
// Configuration macro
//   INT2FP_INEXACT_EN  adds the registered inexact output
// -----------------------------------------------------------------------------
module int_to_fp #(
    parameter int INT_W = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [INT_W-1:0] int_in,
    output logic             ready,
    output logic             done,
    output logic             sign_out,
    output logic [3:0]       exp_out,
    output logic [7:0]       frac_out
`ifdef INT2FP_INEXACT_EN
    ,
    output logic             inexact
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_NORM,
        S_ROUND,
        S_DONE
    } state_t;

    // A value entering the shifter has its leading one at most at bit INT_W-1.
    // So the starting exponent is INT_W.
    localparam logic [3:0] EXP_INIT = 4'(INT_W);

    // This mask selects the bits below the guard bit that form the sticky bit.
    // It is all zeros when INT_W=9.
    localparam logic [INT_W-1:0] STICKY_MASK = INT_W'((32'd1 << (INT_W - 9)) - 32'd1);

    state_t             state_q, state_d;
    logic               sign_q, sign_d;
    logic [INT_W-1:0]   mag_q, mag_d;
    logic [3:0]         exp_q, exp_d;
    logic               done_q, done_d;
    logic               sign_out_q, sign_out_d;
    logic [3:0]         exp_out_q, exp_out_d;
    logic [7:0]         frac_out_q, frac_out_d;

    logic [7:0]         round_f;
    logic               round_g;
    logic               round_st;
    logic               round_up;

`ifdef INT2FP_INEXACT_EN
    logic               inexact_q, inexact_d;
`endif

    // Rounding fields come from the normalised magnitude. These fields are only
    // consumed in ROUND, where the magnitude's leading one (if any) is at the MSB.
    always_comb begin
        round_f  = mag_q[INT_W-1 -: 8];
        round_g  = mag_q[INT_W-9];
        round_st = |(mag_q & STICKY_MASK);
        round_up = round_g & (round_st | round_f[0]);
    end

    // This block holds the next-state and next-output logic of the converter FSM.
    // The result outputs only change on the ROUND edge. They otherwise hold.
    always_comb begin
        state_d    = state_q;
        sign_d     = sign_q;
        mag_d      = mag_q;
        exp_d      = exp_q;
        done_d     = 1'b0;
        sign_out_d = sign_out_q;
        exp_out_d  = exp_out_q;
        frac_out_d = frac_out_q;
`ifdef INT2FP_INEXACT_EN
        inexact_d  = inexact_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sign_d  = int_in[INT_W-1];
                    // The most negative input maps to 2^(INT_W-1), which still
                    // fits as an unsigned INT_W-bit magnitude.
                    mag_d   = int_in[INT_W-1] ? ((~int_in) + {{(INT_W-1){1'b0}}, 1'b1})
                                              : int_in;
                    exp_d   = EXP_INIT;
                    state_d = S_NORM;
                end
            end

            S_NORM: begin
                if ((mag_q == '0) || mag_q[INT_W-1]) begin
                    state_d = S_ROUND;
                end else begin
                    mag_d = {mag_q[INT_W-2:0], 1'b0};
                    exp_d = exp_q - 4'd1;
                end
            end

            S_ROUND: begin
                if (mag_q == '0) begin
                    sign_out_d = 1'b0;
                    exp_out_d  = 4'd0;
                    frac_out_d = 8'd0;
`ifdef INT2FP_INEXACT_EN
                    inexact_d  = 1'b0;
`endif
                end else begin
                    sign_out_d = sign_q;
                    // When the increment carries out of an all-ones fraction, the
                    // fraction renormalises to 0.1000_0000 and the exponent
                    // increases by one.
                    if (round_up && (round_f == 8'hFF)) begin
                        frac_out_d = 8'h80;
                        exp_out_d  = exp_q + 4'd1;
                    end else begin
                        frac_out_d = round_f + {7'd0, round_up};
                        exp_out_d  = exp_q;
                    end
`ifdef INT2FP_INEXACT_EN
                    inexact_d  = round_g | round_st;
`endif
                end
                done_d  = 1'b1;
                state_d = S_DONE;
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // These are the state and output registers. An asynchronous reset aborts any
    // conversion in flight and does not produce a done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            sign_q     <= 1'b0;
            mag_q      <= '0;
            exp_q      <= 4'd0;
            done_q     <= 1'b0;
            sign_out_q <= 1'b0;
            exp_out_q  <= 4'd0;
            frac_out_q <= 8'd0;
`ifdef INT2FP_INEXACT_EN
            inexact_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            sign_q     <= sign_d;
            mag_q      <= mag_d;
            exp_q      <= exp_d;
            done_q     <= done_d;
            sign_out_q <= sign_out_d;
            exp_out_q  <= exp_out_d;
            frac_out_q <= frac_out_d;
`ifdef INT2FP_INEXACT_EN
            inexact_q  <= inexact_d;
`endif
        end
    end

    assign ready    = (state_q == S_IDLE);
    assign done     = done_q;
    assign sign_out = sign_out_q;
    assign exp_out  = exp_out_q;
    assign frac_out = frac_out_q;
`ifdef INT2FP_INEXACT_EN
    assign inexact  = inexact_q;
`endif

endmodule

// File: tb/tb_int_to_fp.sv
// -----------------------------------------------------------------------------
// tb_int_to_fp
//
// This bench drives int_to_fp with INT_W=12. A table of hand-derived vectors is
// followed by random vectors, whose expected values come from an independent
// arithmetic rounding model. Expected results are queued when start is driven.
// A monitor pops and compares them, including the latency, whenever done is
// seen. Hand-written sequences cover reset, a start pulse during
// normalisation, result hold and reset mid-conversion.
// -----------------------------------------------------------------------------
module tb_int_to_fp;

    localparam int INT_W = 12;

    typedef struct {
        logic [11:0] val;
        logic        s;
        logic [3:0]  e;
        logic [7:0]  f;
        logic        inx;
        int          lat;
        int          t0;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [11:0] int_in;
    logic        ready;
    logic        done;
    logic        sign_out;
    logic [3:0]  exp_out;
    logic [7:0]  frac_out;
`ifdef INT2FP_INEXACT_EN
    logic        inexact;
`endif

    int   checks     = 0;
    int   failures   = 0;
    int   cycle_cnt  = 0;
    int   done_count = 0;
    vec_t sb[$];
    vec_t tbl[11];

    int_to_fp #(.INT_W(INT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .int_in   (int_in),
        .ready    (ready),
        .done     (done),
        .sign_out (sign_out),
        .exp_out  (exp_out),
        .frac_out (frac_out)
`ifdef INT2FP_INEXACT_EN
        ,
        .inexact  (inexact)
`endif
    );

    // This block generates a free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // This block counts rising edges. The monitor uses the count to measure the
    // latency from the start-sampling edge.
    always @(posedge clk) begin
        cycle_cnt <= cycle_cnt + 1;
    end

    // This task performs one comparison and reports any mismatch.
    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // This is the reference model. It finds the bit length of the magnitude and
    // keeps the top 8 bits. It then rounds on the arithmetic remainder against
    // half an ulp, with ties to even.
    function automatic vec_t model(input logic [11:0] v);
        vec_t r;
        int vi, m, e, sh, q, rem, half;
        vi    = int'($signed(v));
        m     = (vi < 0) ? -vi : vi;
        r.val = v;
        r.t0  = 0;
        r.s   = 1'b0;
        r.e   = 4'd0;
        r.f   = 8'd0;
        r.inx = 1'b0;
        r.lat = 2;
        if (m == 0) return r;
        e = 0;
        while ((m >> e) != 0) e++;
        r.s   = (vi < 0);
        r.lat = INT_W - e + 2;
        rem   = 0;
        if (e <= 8) begin
            q = m << (8 - e);
        end else begin
            sh   = e - 8;
            q    = m >> sh;
            rem  = m - (q << sh);
            half = 1 << (sh - 1);
            if ((rem > half) || ((rem == half) && ((q % 2) == 1))) q++;
        end
        if (q == 256) begin
            q = 128;
            e++;
        end
        r.e   = 4'(e);
        r.f   = 8'(q);
        r.inx = (rem != 0);
        return r;
    endfunction

    // This task waits for ready and drives one start pulse. It queues the
    // expectation and then scrambles int_in, which must have no effect.
    task automatic apply_stimulus(input vec_t v);
        int n;
        n = 0;
        @(negedge clk);
        while (!ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            check_output("ready_timeout", 0, 1);
        end else begin
            start  = 1'b1;
            int_in = v.val;
            v.t0   = cycle_cnt + 1;
            sb.push_back(v);
            @(negedge clk);
            start  = 1'b0;
            int_in = ~v.val;
            check_output("ready_busy", int'(ready), 0);
        end
    endtask

    // This task waits, with a cycle budget, until every queued result has been
    // compared.
    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check_output("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    // This is the monitor. Every done pulse must match the oldest queued
    // expectation, including its latency. A done with nothing pending is an error.
    initial begin
        vec_t x;
        forever begin
            @(posedge clk);
            #1;
            if (!reset && done) begin
                done_count++;
                if (sb.size() == 0) begin
                    check_output("unexpected_done", 1, 0);
                end else begin
                    x = sb.pop_front();
                    check_output($sformatf("sign[%0d]", $signed(x.val)), int'(sign_out), int'(x.s));
                    check_output($sformatf("exp[%0d]", $signed(x.val)), int'(exp_out), int'(x.e));
                    check_output($sformatf("frac[%0d]", $signed(x.val)), int'(frac_out), int'(x.f));
                    check_output($sformatf("latency[%0d]", $signed(x.val)), cycle_cnt - x.t0, x.lat);
`ifdef INT2FP_INEXACT_EN
                    check_output($sformatf("inexact[%0d]", $signed(x.val)), int'(inexact), int'(x.inx));
`endif
                end
            end
        end
    end

    // This is the main test sequence.
    initial begin
        vec_t v;
        int   dc;

        tbl[0]  = '{12'd1,      1'b0, 4'd1,  8'h80, 1'b0, 13, 0};
        tbl[1]  = '{-12'sd5,    1'b1, 4'd3,  8'hA0, 1'b0, 11, 0};
        tbl[2]  = '{12'd0,      1'b0, 4'd0,  8'h00, 1'b0, 2,  0};
        tbl[3]  = '{12'd257,    1'b0, 4'd9,  8'h80, 1'b1, 5,  0};
        tbl[4]  = '{12'd259,    1'b0, 4'd9,  8'h82, 1'b1, 5,  0};
        tbl[5]  = '{12'd511,    1'b0, 4'd10, 8'h80, 1'b1, 5,  0};
        tbl[6]  = '{-12'sd2048, 1'b1, 4'd12, 8'h80, 1'b0, 2,  0};
        tbl[7]  = '{12'd2047,   1'b0, 4'd12, 8'h80, 1'b1, 3,  0};
        tbl[8]  = '{12'd256,    1'b0, 4'd9,  8'h80, 1'b0, 5,  0};
        tbl[9]  = '{-12'sd1,    1'b1, 4'd1,  8'h80, 1'b0, 13, 0};
        tbl[10] = '{12'd100,    1'b0, 4'd7,  8'hC8, 1'b0, 7,  0};

        reset  = 1'b1;
        start  = 1'b0;
        int_in = 12'd0;
        repeat (3) @(negedge clk);
        check_output("reset_done", int'(done), 0);
        check_output("reset_sign", int'(sign_out), 0);
        check_output("reset_exp", int'(exp_out), 0);
        check_output("reset_frac", int'(frac_out), 0);
        check_output("reset_ready", int'(ready), 1);
`ifdef INT2FP_INEXACT_EN
        check_output("reset_inexact", int'(inexact), 0);
`endif
        reset = 1'b0;
        @(negedge clk);

        // The table vectors are issued back to back. Each one waits only for ready.
        for (int i = 0; i < 11; i++) begin
            apply_stimulus(tbl[i]);
        end
        wait_drain();

        // These are random vectors checked against the arithmetic model.
        for (int i = 0; i < 30; i++) begin
            v = model(12'($urandom_range(0, 4095)));
            apply_stimulus(v);
        end
        wait_drain();

        // A start pulse during normalisation must be ignored, and only one
        // done may follow.
        dc = done_count;
        apply_stimulus(tbl[0]);
        repeat (3) @(negedge clk);
        start  = 1'b1;
        int_in = 12'd5;
        @(negedge clk);
        start  = 1'b0;
        wait_drain();
        repeat (15) @(negedge clk);
        check_output("ignored_start_done_count", done_count - dc, 1);

        // The results hold their last value while idle.
        check_output("hold_sign", int'(sign_out), 0);
        check_output("hold_exp", int'(exp_out), 1);
        check_output("hold_frac", int'(frac_out), 8'h80);
        check_output("hold_done", int'(done), 0);

        // Reset asserted during normalisation aborts at once and gives no done.
        apply_stimulus(tbl[9]);
        repeat (3) @(negedge clk);
        dc    = done_count;
        reset = 1'b1;
        sb.delete();
        #1;
        check_output("abort_ready", int'(ready), 1);
        check_output("abort_sign", int'(sign_out), 0);
        check_output("abort_exp", int'(exp_out), 0);
        check_output("abort_frac", int'(frac_out), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check_output("abort_no_done", done_count - dc, 0);

        // A conversion still works after the abort.
        apply_stimulus(tbl[4]);
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
